// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the serial 7-segment display driver.
//   state_e   - frame sequencer states
//   SEG_BLANK - code for a fully dark digit (active-low segments)
//   hex_seg() - hex nibble to active-low {dp,g,f,e,d,c,b,a} pattern, dp off
package seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: one digit's segment byte.
//   nibble_i - hex value of the digit
//   point_i  - 1 lights the decimal point
//   le_i     - 1 blanks the whole digit (overrides point)
//   code_o   - active-low {dp,g,f,e,d,c,b,a}
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       point_i,
  input  logic       le_i,
  output logic [7:0] code_o
);

  logic [7:0] raw;

  always_comb begin
    raw = hex_seg(nibble_i);
    if (le_i) begin
      code_o = SEG_BLANK;
    end else begin
      code_o = {raw[7] & ~point_i, raw[6:0]};
    end
  end

endmodule

// File: rtl/seg_p2s_driver.sv
// seg_p2s_driver: decodes a hex value to 7-seg bytes and shifts the frame
// MSB first into the display's shift-register chain, then pulses the latch.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request one frame (honoured only when idle)
//   num         - hex value, nibble i -> digit i
//   point / le  - per-digit decimal point enable / blank
//   busy, done  - frame in progress / one-cycle completion pulse
//   seg_clk, seg_sout, seg_latch, seg_clrn - serial display interface
module seg_p2s_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     le,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_sout,
  output logic                  seg_latch,
  output logic                  seg_clrn
);

  localparam int unsigned      FRAME_W  = 8 * DIGITS;
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       BIT_LAST = 6'(FRAME_W - 1);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   frame_load;
  logic [5:0]           bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic                 sout_q, sout_d;
  logic                 clrn_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    hex_to_seg u_hex_to_seg (
      .nibble_i (num[4*i +: 4]),
      .point_i  (point[i]),
      .le_i     (le[i]),
      .code_o   (frame_load[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      sout_q  <= 1'b0;
      clrn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      sout_q  <= sout_d;
      clrn_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    sout_d  = sout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_d = frame_load;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sout_d  = frame_q[FRAME_W-1];
        bit_d   = '0;
        div_d   = '0;
        sclk_d  = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling seg_clk: present the next bit, or finish after the last one.
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_LATCH;
            end else begin
              bit_d   = bit_q + 6'd1;
              frame_d = {frame_q[FRAME_W-2:0], 1'b0};
              sout_d  = frame_q[FRAME_W-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_LATCH);
    done      = (state_q == ST_DONE);
    seg_latch = (state_q == ST_LATCH);
    seg_clk   = sclk_q;
    seg_sout  = sout_q;
    seg_clrn  = clrn_q;
  end

endmodule

// File: tb/tb_seg_p2s_driver.sv
module tb_seg_p2s_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [15:0] num;
  logic [3:0]  point, le;
  logic        busy, done, seg_clk, seg_sout, seg_latch, seg_clrn;

  logic        rst1_n, start1;
  logic        busy1, done1, sclk1, sout1, latch1, clrn1;

  seg_p2s_driver #(.CLK_DIV(2), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num), .point(point), .le(le),
    .busy(busy), .done(done), .seg_clk(seg_clk), .seg_sout(seg_sout),
    .seg_latch(seg_latch), .seg_clrn(seg_clrn)
  );

  seg_p2s_driver #(.CLK_DIV(1), .DIGITS(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .num(16'h0123), .point(4'b0000), .le(4'b0000),
    .busy(busy1), .done(done1), .seg_clk(sclk1), .seg_sout(sout1),
    .seg_latch(latch1), .seg_clrn(clrn1)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int d1_frames  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] frame;
    int          start_edge;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one frame request; inputs are scrambled right after capture.
  task automatic send(input logic [15:0] n, input logic [3:0] p, input logic [3:0] l,
                      input logic [31:0] f);
    exp_t e;
    @(negedge clk);
    num = n; point = p; le = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0; num = ~n; point = ~p; le = ~l;
    e.frame = f;
    e.start_edge = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic quiet_check(input string name, input int cycles);
    int hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (seg_latch || done || busy) hits++;
    end
    chk(name, 32'(hits), 32'd0);
  endtask

  task automatic mid_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk({name, "_outs"}, {26'd0, busy, done, seg_clk, seg_sout, seg_latch, seg_clrn}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_clrn_held"}, 32'(seg_clrn), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk({name, "_clrn_rel"}, 32'(seg_clrn), 32'd1);
  endtask

  // Monitor for the CLK_DIV=2 instance: assemble bits on seg_clk rises, check on done.
  initial begin
    logic [31:0] acc;
    int          nbits, nbusy, nlatch;
    logic        prev;
    exp_t        e;
    acc = '0; nbits = 0; nbusy = 0; nlatch = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = '0; nbits = 0; nbusy = 0; nlatch = 0; prev = 1'b0;
      end else begin
        if (seg_clk && !prev) begin
          acc = {acc[30:0], seg_sout};
          nbits++;
        end
        prev = seg_clk;
        if (busy) nbusy++;
        if (seg_latch) nlatch++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("frame", acc, e.frame);
            chk("nbits", 32'(nbits), 32'd32);
            chk("done_latency", 32'(cyc - e.start_edge), 32'd131);
            chk("busy_cycles", 32'(nbusy), 32'd131);
            chk("latch_cycles", 32'(nlatch), 32'd2);
          end
          acc = '0; nbits = 0; nbusy = 0; nlatch = 0;
        end
      end
    end
  end

  // Monitor for the CLK_DIV=1 instance with start held high.
  initial begin
    logic [31:0] acc;
    int          nbits, last_rise, last_done;
    logic        prev;
    acc = '0; nbits = 0; last_rise = 0; last_done = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1_n && d1_frames < 4) begin
        if (sclk1 && !prev) begin
          if (nbits > 0) chk("d1_rise_spacing", 32'(cyc - last_rise), 32'd2);
          last_rise = cyc;
          acc = {acc[30:0], sout1};
          nbits++;
        end
        prev = sclk1;
        if (done1) begin
          chk("d1_frame", acc, 32'hC0F9A4B0);
          chk("d1_nbits", 32'(nbits), 32'd32);
          if (d1_frames > 0) chk("d1_done_period", 32'(cyc - last_done), 32'd68);
          last_done = cyc;
          d1_frames++;
          acc = '0;
          nbits = 0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num = '0; point = '0; le = '0;
    rst1_n = 1'b0; start1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {26'd0, busy, done, seg_clk, seg_sout, seg_latch, seg_clrn}, 32'd0);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    @(negedge clk);
    chk("reset_clrn_rel", 32'(seg_clrn), 32'd1);

    // Plain digits, no points, no blanking.
    send(16'h0123, 4'b0000, 4'b0000, 32'hC0F9A4B0);
    wait_done("t2");

    // Point on digit 0, digit 2 blanked.
    send(16'hABCD, 4'b0001, 4'b0100, 32'h88FFC621);
    wait_done("t3");

    // Second start mid-frame must be ignored.
    send(16'h4567, 4'b1010, 4'b0000, 32'h199202F8);
    repeat (48) @(negedge clk);
    start = 1'b1; num = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4");
    quiet_check("t4_no_second_frame", 10);

    // Reset early in a frame.
    send(16'h89EF, 4'b1111, 4'b0000, 32'h0);
    repeat (40) @(negedge clk);
    mid_reset("t1");
    quiet_check("t1_quiet", 20);

    // Reset around bit 17, then a clean frame.
    send(16'hBEEF, 4'b0000, 4'b0000, 32'h8386868E);
    repeat (68) @(negedge clk);
    mid_reset("t5");
    quiet_check("t5_quiet", 150);
    send(16'h0123, 4'b0000, 4'b0000, 32'hC0F9A4B0);
    wait_done("t5_fresh");

    repeat (5) @(negedge clk);
    chk("d1_frames_seen", 32'(d1_frames), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
